// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the mux_arb_reg stream multiplexer family.
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, used to size channel indices (n >= 2).
  function automatic int mux_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// Combinational rotating-priority search: first requester at or after ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter  int N_CH  = 16,
  localparam int SEL_W = mux_clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Scan farthest-first so the position nearest ptr is the one that sticks.
  always_comb begin
    int w_pos;
    gnt_idx = {SEL_W{1'b0}};
    gnt_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_pos = (int'(ptr) + i >= N_CH) ? (int'(ptr) + i - N_CH) : (int'(ptr) + i);
      if (req[w_pos[SEL_W-1:0]]) begin
        gnt_idx = w_pos[SEL_W-1:0];
        gnt_vld = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N-channel valid/ready stream mux, fixed-select or round-robin.
// Optional packet hold (in_last/out_last ports) when MUX_ARB_HOLD_EN is defined.
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter  int N_CH   = 16,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = mux_clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
`ifdef MUX_ARB_HOLD_EN
  ,
  input  logic [N_CH-1:0]        in_last,
  output logic                   out_last
`endif
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_ptr;
  logic              r_lock;
  logic [SEL_W-1:0]  r_lock_ch;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_rr_vld;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_gnt_vld;
  logic              w_load_en;
  logic              w_xfer;
  logic              w_beat_last;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [DATA_W-1:0] w_gnt_data;

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_vld (w_rr_vld)
  );

  // Grant source: an open packet beats both arbitration modes.
  always_comb begin
    w_gnt_idx = {SEL_W{1'b0}};
    w_gnt_vld = 1'b0;
    if (r_lock) begin
      w_gnt_idx = r_lock_ch;
      w_gnt_vld = in_valid[r_lock_ch];
    end else if (mode == MODE_RR) begin
      w_gnt_idx = w_rr_idx;
      w_gnt_vld = w_rr_vld;
    end else begin
      w_gnt_idx = sel;
      w_gnt_vld = (int'(sel) < N_CH) && in_valid[sel];
    end
  end

`ifdef MUX_ARB_HOLD_EN
  assign w_beat_last = in_last[w_gnt_idx];
`else
  assign w_beat_last = 1'b1;
`endif

  assign w_load_en  = !r_out_valid || out_ready;
  assign w_xfer     = rst_n && w_load_en && w_gnt_vld;
  assign w_gnt_data = in_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_ptr_nxt  = (w_gnt_idx == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}} : (w_gnt_idx + SEL_W'(1));

  // One-hot ready toward the granted channel only.
  always_comb begin
    in_ready = {N_CH{1'b0}};
    if (w_xfer) begin
      in_ready[w_gnt_idx] = 1'b1;
    end else begin
      in_ready = {N_CH{1'b0}};
    end
  end

  // Output stage, round-robin pointer and packet lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_ch    <= {SEL_W{1'b0}};
      r_ptr       <= {SEL_W{1'b0}};
      r_lock      <= 1'b0;
      r_lock_ch   <= {SEL_W{1'b0}};
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_ch    <= w_gnt_idx;
      r_lock      <= !w_beat_last;
      r_lock_ch   <= w_gnt_idx;
      if (mode == MODE_RR && w_beat_last) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_HOLD_EN
  logic r_out_last;

  // Packet-end flag travels with the data beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= w_beat_last;
    end
  end

  assign out_last = r_out_last;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: vector table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_mux_arb_reg;
  import mux_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          mode = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic [N-1:0]  in_valid = '0;
  logic [N*DW-1:0] in_data = 32'hA3A2A1A0;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_ready = 1'b1;
`ifdef MUX_ARB_HOLD_EN
  logic [N-1:0]  in_last = 4'b1111;
  logic          out_last;
  logic [2:0]    in_last3 = 3'b111;
  logic          out_last3;
`endif

  logic          mode3 = 1'b0;
  logic [1:0]    sel3 = 2'd0;
  logic [2:0]    in_valid3 = 3'b000;
  logic [23:0]   in_data3 = 24'hC2C1C0;
  logic [2:0]    in_ready3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [1:0]    out_ch3;
  logic          out_ready3 = 1'b1;

  mux_arb_reg #(.N_CH(N), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
`ifdef MUX_ARB_HOLD_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );

  mux_arb_reg #(.N_CH(3), .DATA_W(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
`ifdef MUX_ARB_HOLD_EN
    , .in_last(in_last3), .out_last(out_last3)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: what the output register holds, and the arbitration pointer.
  int m_valid, m_data, m_ch, m_ptr, m_lock, m_lock_ch;

  // Starts at a negedge with inputs driven; returns at the following negedge.
  task automatic model_step();
    int g;
    bit gv, xfer, last;
    logic [N-1:0] exp_rdy;
    g = 0;
    gv = 1'b0;
    if (m_lock != 0) begin
      g = m_lock_ch;
      gv = in_valid[g];
    end else if (mode == MODE_FIXED) begin
      g = int'(sel);
      gv = in_valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!gv && in_valid[c]) begin
          g = c;
          gv = 1'b1;
        end
      end
    end
    xfer = gv && (m_valid == 0 || out_ready);
    exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
    last = 1'b1;
`ifdef MUX_ARB_HOLD_EN
    last = in_last[g];
`endif
    #1 check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (xfer) begin
      m_valid = 1;
      m_data = int'(in_data[g*DW +: DW]);
      m_ch = g;
      if (mode == MODE_RR && last) m_ptr = (g + 1) % N;
      m_lock = last ? 0 : 1;
      m_lock_ch = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("rand_out_valid", 32'(out_valid), 32'(m_valid));
    check("rand_out_data", 32'(out_data), 32'(m_data));
    check("rand_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_ARB_HOLD_EN
    if (xfer) check("rand_out_last", 32'(out_last), 32'(last));
`endif
  endtask

  // One cycle with explicit expectations on ready (before the edge) and outputs (after).
  task automatic cyc(input string name, input logic [3:0] e_rdy, input logic e_vld,
                     input logic [7:0] e_data, input logic [1:0] e_ch);
    #1 check({name, "_in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    @(negedge clk);
    check({name, "_out_valid"}, 32'(out_valid), 32'(e_vld));
    check({name, "_out_data"}, 32'(out_data), 32'(e_data));
    check({name, "_out_ch"}, 32'(out_ch), 32'(e_ch));
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_data;
    logic [1:0] e_ch;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[2]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA3, 2'd3};
    tbl[13] = '{1'b1, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    tbl[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      mode = tbl[r].mode;
      sel = tbl[r].sel;
      in_valid = tbl[r].vld;
      out_ready = tbl[r].rdy;
      cyc($sformatf("tbl%0d", r), tbl[r].e_rdy, tbl[r].e_vld, tbl[r].e_data, tbl[r].e_ch);
    end

    // Backpressure: output held, no ready upstream, then no bubble on release.
    mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = 32'hA355A1A0;
    cyc("bp_load", 4'b0100, 1'b1, 8'h55, 2'd2);
    in_data = 32'hA366A1A0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 8'h55, 2'd2);
    out_ready = 1'b1;
    cyc("bp_release", 4'b0100, 1'b1, 8'h66, 2'd2);
    in_valid = 4'b0000;
    cyc("bp_drain", 4'b0000, 1'b0, 8'h66, 2'd2);
    in_data = 32'hA3A2A1A0;

    // Three-channel instance: out-of-range select grants nothing.
    mode3 = MODE_FIXED; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1 check("n3_rdy_sel0", 32'(in_ready3), 32'b001);
    @(negedge clk);
    check("n3_valid_sel0", 32'(out_valid3), 32'd1);
    check("n3_data_sel0", 32'(out_data3), 32'hC0);
    sel3 = 2'd3;
    #1 check("n3_rdy_sel3", 32'(in_ready3), 32'b000);
    @(negedge clk);
    check("n3_valid_sel3", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1 check("n3_rdy_sel2", 32'(in_ready3), 32'b100);
    @(negedge clk);
    check("n3_ch_sel2", 32'(out_ch3), 32'd2);
    in_valid3 = 3'b000;

`ifdef MUX_ARB_HOLD_EN
    // Packet hold: ch1 keeps the grant for three beats though ch0/ch2 are valid.
    mode = MODE_RR; out_ready = 1'b1; in_valid = 4'b0001; in_last = 4'b1111;
    cyc("hold_pre", 4'b0001, 1'b1, 8'hA0, 2'd0);
    in_valid = 4'b0111; in_last = 4'b0000;
    cyc("hold_b1", 4'b0010, 1'b1, 8'hA1, 2'd1);
    check("hold_b1_last", 32'(out_last), 32'd0);
    sel = 2'd0;
    cyc("hold_b2", 4'b0010, 1'b1, 8'hA1, 2'd1);
    check("hold_b2_last", 32'(out_last), 32'd0);
    in_last = 4'b0010;
    cyc("hold_b3", 4'b0010, 1'b1, 8'hA1, 2'd1);
    check("hold_b3_last", 32'(out_last), 32'd1);
    in_last = 4'b0000;
    cyc("hold_next", 4'b0100, 1'b1, 8'hA2, 2'd2);
    check("hold_next_last", 32'(out_last), 32'd0);
    in_last = 4'b0100;
    cyc("hold_close", 4'b0100, 1'b1, 8'hA2, 2'd2);
    in_last = 4'b1111;
`endif

    // Mid-stream asynchronous reset with a pointer away from zero.
    mode = MODE_RR; in_valid = 4'b0010; out_ready = 1'b1;
    cyc("pre_rst", 4'b0010, 1'b1, 8'hA1, 2'd1);
    out_ready = 1'b0; in_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_ch", 32'(out_ch), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cyc("post_rst_first", 4'b0001, 1'b1, 8'hA0, 2'd0);

    // Randomised traffic against the reference model.
    m_valid = 1; m_data = 'hA0; m_ch = 0; m_ptr = 1; m_lock = 0; m_lock_ch = 0;
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      in_data = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_HOLD_EN
      in_last = 4'($urandom);
`endif
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Channel choice is either a fixed select (port-driven) or round-robin arbitration among valid channels.
- Generalises the combinational 16:1 one-bit mux tree to streaming datapaths: muxing several producers (FIFOs, engines) onto one shared downstream bus.
- Single output register stage; full throughput (one beat per cycle) under no backpressure.

Parameters:
- N_CH, 16, number of input channels (>=2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), select/channel-index width; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  N_CH  per-channel ready (combinational).
- out_valid  output  1  registered output valid.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. in_ready is all-zero while rst_n is low.
- load_en = !out_valid || out_ready (output register empty or draining this cycle).
- Grant, fixed mode: g=sel; the grant is valid iff sel<N_CH and in_valid[sel]. sel>=N_CH grants nothing.
- Grant, RR mode: g = the first k with in_valid[k], searching ptr, ptr+1, ... N_CH-1, 0, ... ptr-1. No valid channel means no grant.
- in_ready[g] = load_en && grant valid. All other in_ready bits are 0. There is exactly one transfer at most per cycle.
- On transfer: out_data<=in_data[g], out_ch<=g, out_valid<=1. In RR mode, ptr<=(g+1) mod N_CH, wrapping from N_CH-1 to 0.
- On out_ready && out_valid with no new transfer: out_valid<=0. out_data and out_ch hold their values.
- Latency: 1 cycle from input acceptance to out_valid.
- While out_valid && !out_ready, out_data and out_ch are stable and in_ready is all-zero.
- A mode or sel change applies to the next arbitration. ptr is not modified in fixed mode and is retained across mode switches.
- No combinational path from in_valid to out_valid. out_ready→in_ready is combinational, by design.

Optional Feature:
- Macro MUX_ARB_HOLD_EN.
- Defined:
  - Adds ports in_last (input, N_CH) and out_last (output, 1; reset 0; registered with out_data).
  - Accepting a beat from g with in_last[g]=0 locks the grant to g in both modes; sel changes and other valid channels are ignored.
  - The lock releases after the beat with in_last[g]=1 is accepted.
  - While locked, ptr is not advanced; it advances to g+1 on release.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports; arbitration is per beat as above.

Decomposition:
- Package mux_arb_pkg holds:
  - Mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - The shared clog2 function used for SEL_W.
- Sub-module rr_pick: combinational rotating priority search (inputs req[N_CH], ptr[SEL_W]; outputs gnt_idx, gnt_vld). Reused by later arbiters.
- The top level holds the output register, ptr, lock state and ready generation.

Test Plan (N_CH=4, DATA_W=8):
- Reset: hold rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000 immediately, without waiting for a clock edge. After release, the first RR grant goes to ch0.
- Fixed mode: sel=2, in_valid=4'b1111, data ch k = 8'hA0+k, out_ready=1 → out_data=8'hA2 and out_ch=2 every cycle, in_ready=4'b0100. Then sel=3 → the next beat is 8'hA3.
- RR mode: all four valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1 with one beat per cycle. With only in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 8'h55 → out_data held at 8'h55, in_ready=0. On out_ready=1, the next beat loads in the same cycle with no bubble.
- Fixed mode, sel out of range: only possible when N_CH is not a power of two; run with N_CH=3, sel=3 → in_ready=3'b000 and out_valid drops after draining.
- MUX_ARB_HOLD_EN, RR mode: ch1 sends 3 beats with last on the 3rd while ch0/ch2 stay valid → out_ch=1,1,1 then 2. out_last=1 only on the 3rd beat.
